// File: rtl/uart_cmd_pkg.sv
// Shared types and command encodings for the PC-controller UART transmit path.
// Commands are {3-bit opcode, 5-bit payload}.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam logic [2:0] OP_RIGHT   = 3'b000;
    localparam logic [2:0] OP_LEFT    = 3'b001;
    localparam logic [2:0] OP_UP      = 3'b010;
    localparam logic [2:0] OP_DOWN    = 3'b011;
    localparam logic [2:0] OP_SPECIAL = 3'b100;
    localparam logic [2:0] OP_LETTER  = 3'b101;
    localparam logic [2:0] OP_NUMBER  = 3'b110;

    localparam logic [4:0] SP_CENTRE    = 5'b00001;
    localparam logic [4:0] SP_CURSOR_LO = 5'b00010;
    localparam logic [4:0] SP_CURSOR_HI = 5'b01001;
    localparam logic [4:0] SP_LCLICK    = 5'b01010;
    localparam logic [4:0] SP_RCLICK    = 5'b01011;
    localparam logic [4:0] SP_BKSP      = 5'b01111;

    function automatic logic [7:0] mk_cmd(
        input logic [2:0] op,
        input logic [4:0] payload
    );
        return {op, payload};
    endfunction

endpackage

// File: rtl/uart_cmd_tx_if.sv
// Command byte valid/ready handshake into the UART transmit stage.
// The producer is the master; the transmitter is the slave.
interface uart_cmd_tx_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (
        output cmd_data,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd_data,
        input  cmd_valid,
        output cmd_ready
    );
endinterface

// File: rtl/uart_cmd_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo DEPTH.
// Push on full and pop on empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_cmd_tx.sv
// Buffered UART 8N1 command transmitter: FIFO of command bytes feeding
// a start/data/stop serialiser that chains frames back to back.
module uart_cmd_tx
    import uart_cmd_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_cmd_tx_if.slave                  cmd,
    input  logic                          tx_enable,
    output logic                          TxD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_t   state, state_n;
    logic [15:0] baud_cnt, baud_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shreg, sh_n;
    logic        txd_n;
    logic [7:0]  head;
    logic        full, empty;
    logic        push, pop;
    logic        bit_done, can_pop;

    // Ready depends only on occupancy and reset, never on cmd_valid.
    assign cmd.cmd_ready = !full && !reset;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign bit_done      = (baud_cnt == BAUD_LAST);
    assign can_pop       = !empty && tx_enable;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (cmd.cmd_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            TxD      <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shreg    <= sh_n;
            TxD      <= txd_n;
            if (cmd.cmd_valid && !cmd.cmd_ready) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt + 16'd1;
        bit_n   = bit_idx;
        sh_n    = shreg;
        txd_n   = TxD;
        unique case (state)
            ST_IDLE: begin
                baud_n = '0;
                txd_n  = 1'b1;
                if (can_pop) begin
                    state_n = ST_START;
                    sh_n    = head;
                    txd_n   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_n = ST_DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                    txd_n   = shreg[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        sh_n  = {1'b0, shreg[7:1]};
                        txd_n = shreg[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when possible.
                    if (can_pop) begin
                        state_n = ST_START;
                        sh_n    = head;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                        txd_n   = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

    always_comb begin
        pop = 1'b0;
        unique case (state)
            ST_IDLE: pop = can_pop;
            ST_STOP: pop = bit_done && can_pop;
            default: pop = 1'b0;
        endcase
        busy = (state != ST_IDLE) || !empty;
    end
endmodule

// File: tb/tb_uart_cmd_tx.sv
// Bench for uart_cmd_tx: frame-level line model checked every cycle,
// plus an independent UART receiver and directed scenarios.
module tb_uart_cmd_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic       TxD;
    logic       busy;
    logic [3:0] fifo_count;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    uart_cmd_tx_if bus ();

    uart_cmd_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (bus),
        .tx_enable  (tx_enable),
        .TxD        (TxD),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Line value of a frame at cycle t: start, 8 data bits LSB first, stop.
    function automatic logic line_bit(input logic [7:0] b, input int t);
        int k;
        k = t / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    // Frame-level model: a queue of accepted bytes and the frame on the wire.
    logic [7:0] mq[$];
    bit         m_in = 0;
    int         m_t = 0;
    logic [7:0] m_cur = '0;
    bit         m_ovf = 0;
    bit         chk_en = 0;

    always @(posedge clk) begin
        bit fe, st;
        int sz;
        logic e_txd;
        if (reset) begin
            mq.delete();
            m_in   = 0;
            m_ovf  = 0;
            chk_en = 1;
        end else if (chk_en) begin
            sz = mq.size();
            fe = m_in && (m_t == FRAME - 1);
            st = (!m_in || fe) && (sz > 0) && tx_enable;
            if (st) begin
                m_cur = mq.pop_front();
                m_in  = 1;
                m_t   = 0;
            end else if (fe) begin
                m_in = 0;
            end else if (m_in) begin
                m_t++;
            end
            if (bus.cmd_valid) begin
                if (sz < DEPTH) mq.push_back(bus.cmd_data);
                else m_ovf = 1;
            end
        end
        #1;
        if (chk_en) begin
            e_txd = m_in ? line_bit(m_cur, m_t) : 1'b1;
            chk("m_txd", 32'(TxD), 32'(e_txd));
            chk("m_busy", 32'(busy), 32'(m_in || mq.size() != 0));
            chk("m_count", 32'(fifo_count), 32'(mq.size()));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_ready", 32'(bus.cmd_ready),
                32'(!reset && mq.size() < DEPTH));
        end
    end

    // Independent receiver: samples mid-bit, aborts on reset.
    logic [7:0] rx_q[$];
    bit         rx_on = 0;
    int         rx_t = 0;
    logic [7:0] rx_sh = '0;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (TxD === 1'b0) begin
                rx_on = 1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t >= 6 && rx_t <= 34 && (rx_t - 6) % CPB == 0)
                rx_sh[(rx_t - 6) / CPB] = TxD;
            if (rx_t == 38) begin
                chk("rx_stop", 32'(TxD), 32'(1));
                rx_q.push_back(rx_sh);
            end
            if (rx_t == FRAME - 1) rx_on = 0;
        end
    end

    task automatic push_seq(input logic [7:0] b[]);
        foreach (b[i]) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = b[i];
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_fall();
        int n;
        n = 0;
        while (TxD !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("wait_fall", 32'(TxD), 32'(0));
    endtask

    task automatic chk_rx(input string nm, input logic [7:0] exp[]);
        chk({nm, "_n"}, 32'(rx_q.size()), 32'(exp.size()));
        foreach (exp[i])
            if (i < rx_q.size()) chk(nm, 32'(rx_q[i]), 32'(exp[i]));
    endtask

    logic       s1[0:FRAME];
    logic       b1[0:FRAME];
    logic [9:0] pat;
    logic       s2[0:2*FRAME-1];
    logic [3:0] gap;
    logic [7:0] burst[] = '{8'h03, 8'h24, 8'h4A, 8'h6B,
                            8'h8F, 8'hA1, 8'hC5, 8'h8A};

    initial begin
        reset         = 1'b1;
        tx_enable     = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(TxD), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_count", 32'(fifo_count), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        chk("rst_ready", 32'(bus.cmd_ready), 32'(0));
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.cmd_ready), 32'(1));

        // Single frame 0xA5: exact line pattern and busy timing.
        rx_q.delete();
        @(negedge clk);
        push_seq('{8'hA5});
        wait_fall();
        for (int i = 0; i <= FRAME; i++) begin
            s1[i] = TxD;
            b1[i] = busy;
            @(negedge clk);
        end
        for (int j = 0; j < 10; j++) pat[j] = s1[CPB*j + 1];
        chk("a5_pattern", 32'(pat), 32'(10'b1101001010));
        chk("a5_busy_39", 32'(b1[FRAME-1]), 32'(1));
        chk("a5_busy_40", 32'(b1[FRAME]), 32'(0));
        chk_rx("a5_rx", '{8'hA5});

        // Back-to-back clicks: no idle gap between frames.
        rx_q.delete();
        push_seq('{8'h8A, 8'h8B});
        wait_fall();
        for (int i = 0; i < 2*FRAME; i++) begin
            s2[i] = TxD;
            @(negedge clk);
        end
        for (int j = 0; j < 4; j++) gap[j] = s2[FRAME-4+j];
        chk("b2b_stop", 32'(gap), 32'(4'hF));
        chk("b2b_start2", 32'(s2[FRAME]), 32'(0));
        repeat (4) @(negedge clk);
        chk_rx("b2b_rx", '{8'h8A, 8'h8B});

        // Fill with transmit held off, then overflow, then drain.
        rx_q.delete();
        tx_enable = 1'b0;
        push_seq(burst);
        chk("full_count", 32'(fifo_count), 32'(8));
        chk("full_ready", 32'(bus.cmd_ready), 32'(0));
        chk("full_ovf0", 32'(overflow), 32'(0));
        push_seq('{8'hEE});
        chk("ovf_set", 32'(overflow), 32'(1));
        chk("ovf_count", 32'(fifo_count), 32'(8));
        tx_enable = 1'b1;
        repeat (8*FRAME + 8) @(negedge clk);
        chk_rx("drain_rx", burst);
        chk("drain_busy", 32'(busy), 32'(0));

        // tx_enable dropped mid-frame: frame completes, next waits.
        rx_q.delete();
        push_seq('{8'h55, 8'h0F, 8'hF0});
        wait_fall();
        repeat (12) @(negedge clk);
        tx_enable = 1'b0;
        repeat (60) @(negedge clk);
        chk_rx("hold_rx", '{8'h55});
        chk("hold_count", 32'(fifo_count), 32'(2));
        chk("hold_busy", 32'(busy), 32'(1));
        chk("hold_txd", 32'(TxD), 32'(1));
        tx_enable = 1'b1;
        repeat (90) @(negedge clk);
        chk_rx("resume_rx", '{8'h55, 8'h0F, 8'hF0});

        // Reset during data bit 3 with bytes queued.
        rx_q.delete();
        push_seq('{8'h11, 8'h22, 8'h33});
        repeat (16) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus.cmd_ready), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_txd", 32'(TxD), 32'(1));
        chk("midrst_count", 32'(fifo_count), 32'(0));
        chk("midrst_ovf", 32'(overflow), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        repeat (60) @(negedge clk);
        chk("midrst_rx_n", 32'(rx_q.size()), 32'(0));
        chk("midrst_idle", 32'(TxD), 32'(1));

        // Simultaneous push and pop at count 5.
        rx_q.delete();
        tx_enable = 1'b0;
        push_seq('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35});
        chk("pp_pre", 32'(fifo_count), 32'(5));
        tx_enable     = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'h36;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'(5));
        repeat (6*FRAME + 8) @(negedge clk);
        chk_rx("pp_rx", '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36});

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
